// File: rtl/vec_lane_sequencer_pkg.sv
// Shared encodings for the vector lane sequencer: operand types, funct6 codes,
// FSM states and SEW decode.
package vec_pkg;

   localparam logic [2:0] OPT_VV = 3'b001;
   localparam logic [2:0] OPT_VX = 3'b010;
   localparam logic [2:0] OPT_VI = 3'b100;

   localparam logic [5:0] F6_ADD  = 6'b000000;
   localparam logic [5:0] F6_SUB  = 6'b000010;
   localparam logic [5:0] F6_MINU = 6'b000100;
   localparam logic [5:0] F6_MIN  = 6'b000101;
   localparam logic [5:0] F6_MAXU = 6'b000110;
   localparam logic [5:0] F6_MAX  = 6'b000111;
   localparam logic [5:0] F6_AND  = 6'b001001;
   localparam logic [5:0] F6_OR   = 6'b001010;
   localparam logic [5:0] F6_XOR  = 6'b001011;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIN  = 2'd2
   } state_t;

   // Element width in bits; wide enough that reserved vsew codes stay distinguishable.
   function automatic logic [10:0] sew_bits(input logic [2:0] vsew);
      return 11'd8 << vsew;
   endfunction

   function automatic logic op_supported(input logic [5:0] f);
      case (f)
         F6_ADD, F6_SUB, F6_MINU, F6_MIN, F6_MAXU, F6_MAX,
         F6_AND, F6_OR, F6_XOR: return 1'b1;
         default:               return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/vec_lane_sequencer_if.sv
// Decode-side request/response bundle of the vector lane sequencer.
interface vec_lane_sequencer_if #(
   parameter int VLEN = 128,
   parameter int VLW  = $clog2(VLEN) + 1
);
   logic            start;
   logic [5:0]      opcode;
   logic [2:0]      op_type;
   logic [2:0]      vsew;
   logic [VLW-1:0]  vl;
   logic            vm;
   logic [VLEN-1:0] vs1;
   logic [VLEN-1:0] vs2;
   logic [31:0]     rs1;
   logic [4:0]      imm;
   logic [VLEN-1:0] v0;
   logic [VLEN-1:0] vd_old;
   logic            busy;
   logic            done;
   logic            illegal;
   logic [VLEN-1:0] vd;

   modport master (
      output start, opcode, op_type, vsew, vl, vm, vs1, vs2, rs1, imm, v0, vd_old,
      input  busy, done, illegal, vd
   );

   modport slave (
      input  start, opcode, op_type, vsew, vl, vm, vs1, vs2, rs1, imm, v0, vd_old,
      output busy, done, illegal, vd
   );
endinterface

// File: rtl/vec_lane_alu.sv
// Single-element combinational ALU. Operands are left-aligned to the top of the
// ELEN word so signed/unsigned compares see the SEW sign bit in the MSB and
// ignore whatever sits above SEW in the inputs.
module vec_lane_alu
   import vec_pkg::*;
#(
   parameter int ELEN = 64
) (
   input  logic [ELEN-1:0] a,
   input  logic [ELEN-1:0] b,
   input  logic [2:0]      vsew,
   input  logic [5:0]      opcode,
   output logic [ELEN-1:0] result
);

   logic [10:0]     sw;
   logic [ELEN-1:0] a_al;
   logic [ELEN-1:0] b_al;
   logic            lt_s;
   logic            lt_u;

   // Align, compare, and select the element result; bits above SEW are don't-care.
   always_comb begin
      sw = sew_bits(vsew);
      if (int'(sw) >= ELEN) begin
         a_al = a;
         b_al = b;
      end else begin
         a_al = a << (ELEN - int'(sw));
         b_al = b << (ELEN - int'(sw));
      end
      lt_s   = $signed(a_al) < $signed(b_al);
      lt_u   = a_al < b_al;
      result = '0;
      case (opcode)
         F6_ADD:  result = a + b;
         F6_SUB:  result = a - b;
         F6_MINU: result = lt_u ? a : b;
         F6_MIN:  result = lt_s ? a : b;
         F6_MAXU: result = lt_u ? b : a;
         F6_MAX:  result = lt_s ? b : a;
         F6_AND:  result = a & b;
         F6_OR:   result = a | b;
         F6_XOR:  result = a ^ b;
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/vec_lane_sequencer.sv
// Multi-lane vector ALU sequencer: steps L elements per cycle through vd,
// merging results under vl and v0 while leaving other elements undisturbed.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for start; latches operands and vd_old on accept
// ST_RUN  | one group of L elements per cycle until vl_eff is covered
// ST_FIN  | one-cycle done pulse (illegal qualified here), back to IDLE
module vec_lane_sequencer
   import vec_pkg::*;
#(
   parameter int VLEN       = 128,
   parameter int ELEN       = 64,
   parameter int LANES_LOG2 = 2,
   parameter int VLW        = $clog2(VLEN) + 1
) (
   input logic                 clk,
   input logic                 resetn,
   vec_lane_sequencer_if.slave bus
);

   localparam int L  = 1 << LANES_LOG2;
   localparam int BW = VLW + 6;

   state_t          state, state_nxt;
   logic [VLW-1:0]  elem_base, vl_eff_q;
   logic [2:0]      sew_q;
   logic [5:0]      op_q;
   logic            vm_q, scalar_sel_q, illegal_q;
   logic [ELEN-1:0] scalar_q, sew_mask;
   logic [VLEN-1:0] vs1_q, vs2_q, v0_q, vd_q, vd_nxt;

   logic            legal_in;
   logic [VLW-1:0]  vlmax_in, vl_eff_in;
   logic [63:0]     scalar_in;

   logic [L-1:0]           lane_we;
   logic [L-1:0][BW-1:0]   lane_off;
   logic [L-1:0][ELEN-1:0] lane_res;

   // Request decode: legality, vl clamp to VLMAX, and the broadcast scalar.
   always_comb begin
      legal_in  = (bus.vsew <= 3'd3) && (int'(sew_bits(bus.vsew)) <= ELEN) &&
                  (bus.op_type inside {OPT_VV, OPT_VX, OPT_VI}) && op_supported(bus.opcode);
      vlmax_in  = VLW'(VLEN) >> ({1'b0, bus.vsew} + 4'd3);
      vl_eff_in = (bus.vl < vlmax_in) ? bus.vl : vlmax_in;
      scalar_in = (bus.op_type == OPT_VI) ? {{59{bus.imm[4]}}, bus.imm}
                                          : {{32{bus.rs1[31]}}, bus.rs1};
   end

   // State register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= ST_IDLE;
      else         state <= state_nxt;
   end

   // Next-state logic; starts outside IDLE are dropped, not queued.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (bus.start) state_nxt = (!legal_in || vl_eff_in == '0) ? ST_FIN : ST_RUN;
         ST_RUN:  if (({1'b0, elem_base} + (VLW+1)'(L)) >= {1'b0, vl_eff_q}) state_nxt = ST_FIN;
         ST_FIN:  state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   for (genvar i = 0; i < L; i++) begin : g_lane
      logic [VLW-1:0]  e;
      logic [ELEN-1:0] a, b;
      logic [VLEN-1:0] v0_sh;
      assign e           = elem_base + VLW'(i);
      assign lane_off[i] = BW'(e) << ({1'b0, sew_q} + 4'd3);
      assign a           = ELEN'(vs2_q >> lane_off[i]);
      assign b           = scalar_sel_q ? scalar_q : ELEN'(vs1_q >> lane_off[i]);
      assign v0_sh       = v0_q >> e;
      assign lane_we[i]  = (e < vl_eff_q) && (vm_q || v0_sh[0]);

      vec_lane_alu #(.ELEN(ELEN)) u_alu (
         .a      (a),
         .b      (b),
         .vsew   (sew_q),
         .opcode (op_q),
         .result (lane_res[i])
      );
   end

   // Merge the enabled lane results into their SEW slices of vd.
   always_comb begin
      sew_mask = {ELEN{1'b1}} >> (ELEN - int'(sew_bits(sew_q)));
      vd_nxt   = vd_q;
      for (int i = 0; i < L; i++) begin
         if (lane_we[i]) begin
            vd_nxt = (vd_nxt & ~(VLEN'(sew_mask) << lane_off[i])) |
                     (VLEN'(lane_res[i] & sew_mask) << lane_off[i]);
         end
      end
   end

   // Operand capture on accept and per-cycle vd/elem_base update while running.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         vd_q         <= '0;
         elem_base    <= '0;
         illegal_q    <= 1'b0;
         op_q         <= '0;
         sew_q        <= '0;
         vl_eff_q     <= '0;
         vm_q         <= 1'b0;
         scalar_sel_q <= 1'b0;
         scalar_q     <= '0;
         vs1_q        <= '0;
         vs2_q        <= '0;
         v0_q         <= '0;
      end else begin
         case (state)
            ST_IDLE: if (bus.start) begin
               vd_q         <= bus.vd_old;
               elem_base    <= '0;
               illegal_q    <= !legal_in;
               op_q         <= bus.opcode;
               sew_q        <= bus.vsew;
               vl_eff_q     <= vl_eff_in;
               vm_q         <= bus.vm;
               scalar_sel_q <= (bus.op_type != OPT_VV);
               scalar_q     <= ELEN'(scalar_in);
               vs1_q        <= bus.vs1;
               vs2_q        <= bus.vs2;
               v0_q         <= bus.v0;
            end
            ST_RUN: begin
               vd_q      <= vd_nxt;
               elem_base <= elem_base + VLW'(L);
            end
            default: ;
         endcase
      end
   end

   assign bus.busy    = (state == ST_RUN);
   assign bus.done    = (state == ST_FIN);
   assign bus.illegal = illegal_q && (state == ST_FIN);
   assign bus.vd      = vd_q;

endmodule

// File: doc/vec_lane_sequencer.md
Name: vec_lane_sequencer

Overview:
Parametrised multi-lane vector ALU sequencer for the picorv32 vector unit. It supersedes the fixed 1/2/4/8-lane wrapper with these changes:
- a power-of-two lane count of any size;
- a start/busy/done handshake;
- vl-limited iteration;
- v0 masking with mask-undisturbed and tail-undisturbed merging into a full-width destination register.

It sits between vector decode and the vector register file write port.

Parameters:
VLEN, 128, vector register width in bits (power of two, 64..1024)
ELEN, 64, maximum element width in bits (8/16/32/64)
LANES_LOG2, 2, log2 of the lane count; L = 1<<LANES_LOG2 elements are processed per cycle (0..4)
VLW, $clog2(VLEN)+1, width of vl

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
start  in  1  operation request; sampled only in IDLE
opcode  in  6  funct6: ADD 000000, SUB 000010, MINU 000100, MIN 000101, MAXU 000110, MAX 000111, AND 001001, OR 001010, XOR 001011
op_type  in  3  one-hot: VV 001, VX 010, VI 100
vsew  in  3  SEW = 8<<vsew
vl  in  VLW  active element count
vm  in  1  1 = unmasked, 0 = masked by v0
vs1  in  VLEN  source 1 (used for VV)
vs2  in  VLEN  source 2
rs1  in  32  scalar operand (used for VX)
imm  in  5  immediate (used for VI)
v0  in  VLEN  mask register; bit e masks element e
vd_old  in  VLEN  previous destination contents
busy  out  1  operation in flight
done  out  1  one-cycle completion pulse
illegal  out  1  valid with done; set on an unsupported configuration
vd  out  VLEN  result register

Behaviour:
- Reset is asynchronous, active-low. It forces: state IDLE, busy=0, done=0, illegal=0, vd=0, elem_base=0. A reset asserted mid-operation aborts the operation; no done pulse is produced.
- FSM states: IDLE, RUN, FIN.
- IDLE:
  - When start=1, latch all inputs and set vd <= vd_old.
  - Compute VLMAX = VLEN>>(vsew+3) and vl_eff = min(vl, VLMAX).
  - Illegal when any of: vsew>3; SEW>ELEN; op_type not one-hot; opcode not in the supported list. Illegal -> FIN with illegal=1 and vd = vd_old.
  - vl_eff==0 -> FIN with illegal=0 and vd = vd_old.
  - Otherwise -> RUN with elem_base=0. busy=1 from the next cycle.
- RUN, each cycle: lane i handles element e = elem_base+i, for i = 0..L-1.
  - Element e is written iff e < vl_eff and (vm || v0[e]). Its vd slice [e*SEW +: SEW] gets the lane result.
  - Every other element keeps its current value (undisturbed). This includes masked-off elements, tail elements, and lanes with e >= VLMAX.
  - Then elem_base += L. When elem_base+L >= vl_eff, go to FIN.
  - Number of RUN cycles = ceil(vl_eff/L).
- FIN: done=1 for exactly one cycle. busy drops to 0 in the same cycle. Then -> IDLE.
  - vd holds its value until the next accepted start.
  - start asserted while busy or in FIN is ignored, not queued.
- Latency: start at edge T -> done at edge T+1+ceil(vl_eff/L). Degenerate and illegal cases complete at T+1.
- Operand rules:
  - VX: rs1 is truncated to SEW, or sign-extended to SEW when SEW=64.
  - VI: imm is sign-extended to SEW.
  - Arithmetic wraps modulo 2^SEW.
  - MIN/MAX compare signed; MINU/MAXU compare unsigned.
- Timing: element selection is a barrel index of width log2(VLEN). It must not combine vl comparison and result muxing in a way that exceeds one cycle; the intended structure is a registered elem_base plus per-lane combinational slices.

Decomposition:
- Package vec_pkg holds: op_type constants (VV/VX/VI); funct6 opcode constants; FSM state encoding; a SEW decode function (vsew -> bit width).
- One sub-module, vec_lane_alu: a single-element combinational ALU with ports a, b (ELEN), vsew, opcode and result (ELEN). It is SEW-aware for sign handling. It is instantiated L times in a generate loop.

Test Plan:
1. VLEN=128, L=4, vsew=2, VV ADD, vl=4, vm=1, vs1 elems {1,2,3,4}, vs2 {10,20,30,40} -> one RUN cycle; done at T+2; vd = {11,22,33,44}.
2. vsew=0, VX SUB, rs1=0x105, vl=10, vs2 all 0x20, vd_old all 0xAA -> 3 RUN cycles; bytes 0..9 = 0x1B; bytes 10..15 = 0xAA.
3. vsew=1, VI MAX, imm=5'b11111 (-1), vm=0, v0=0x00F0, vl=8, vs2 elems = -5 -> elems 4..7 = 0xFFFF; elems 0..3 = vd_old.
4. vsew=3 with ELEN=32 -> done at T+1, illegal=1, vd = vd_old. Separately, vl=0 -> done at T+1, illegal=0, vd = vd_old.
5. vl=200 with vsew=2 (VLMAX=4) -> clamped to 4; a start pulse during RUN is ignored; exactly one done pulse.
6. Assert resetn=0 mid-RUN (asynchronously) -> busy, done and vd go to 0 immediately; a following start runs cleanly from element 0.
